// File: rtl/cpu_pkg.sv
// Shared types and constants for the exec_ctrl instruction sequencer.
// Covers the opcode map, the FSM state encoding and register-file geometry.
package cpu_pkg;

    localparam int REG_W = 8;
    localparam int NREGS = 4;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_ADD = 4'h2,
        OP_AND = 4'h3,
        OP_XOR = 4'h4,
        OP_MOV = 4'h5,
        OP_LDI = 4'h8,
        OP_JZ  = 4'h9,
        OP_HLT = 4'hF
    } opcode_t;

    typedef enum logic [2:0] {
        S_FETCH    = 3'd0,
        S_DECODE   = 3'd1,
        S_EXEC     = 3'd2,
        S_FETCH_OP = 3'd3,
        S_HALT     = 3'd4
    } state_t;

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_MOV);
    endfunction

    function automatic logic has_operand(input logic [3:0] op);
        return (op == OP_LDI) || (op == OP_JZ);
    endfunction

endpackage

// File: rtl/exec_regfile.sv
// 4 x 8-bit register file: two combinational read ports, one synchronous
// write port and a combinational debug read port.
module exec_regfile
    import cpu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [1:0]       waddr,
    input  logic [REG_W-1:0] wdata,
    input  logic [1:0]       raddr_a,
    output logic [REG_W-1:0] rdata_a,
    input  logic [1:0]       raddr_b,
    output logic [REG_W-1:0] rdata_b,
    input  logic [1:0]       dbg_sel,
    output logic [REG_W-1:0] dbg_data
);

    logic [REG_W-1:0] regs [NREGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    // Reads see the pre-write value, so rd == rs uses the old contents.
    assign rdata_a  = regs[raddr_a];
    assign rdata_b  = regs[raddr_b];
    assign dbg_data = regs[dbg_sel];

endmodule

// File: rtl/exec_ctrl.sv
// Multi-cycle fetch/decode/execute sequencer driving an external ALU.
// Optional EXEC_CTRL_RETIRE_CNT_EN adds a 16-bit retired-instruction counter.
// imem handshake: a fetch completes on any cycle where imem_req and imem_ack
// are both high; req and addr stay stable until then, ack without req is ignored.
module exec_ctrl
    import cpu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [7:0]       imem_addr,
    input  logic             imem_ack,
    input  logic [7:0]       imem_data,
    output logic [3:0]       alu_opcode,
    output logic [1:0]       alu_control,
    output logic [REG_W-1:0] alu_rs1,
    output logic [REG_W-1:0] alu_rs2,
    input  logic [REG_W-1:0] alu_rd,
    input  logic             alu_is_zero,
    output logic [7:0]       pc,
    output logic             zero_flag,
    output logic             halted,
    input  logic [1:0]       dbg_sel,
    output logic [REG_W-1:0] dbg_data,
    output state_t           fsm_state
`ifdef EXEC_CTRL_RETIRE_CNT_EN
    ,
    output logic [15:0]      retire_cnt
`endif
);

    state_t           state, state_nxt;
    logic [7:0]       pc_nxt;
    logic [7:0]       ir, ir_nxt;
    logic             zero_nxt;
    logic             req_c;
    logic             rf_we;
    logic [REG_W-1:0] rf_wdata;
    logic [3:0]       op;

    assign op = ir[7:4];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_FETCH;
            pc        <= 8'h00;
            ir        <= 8'h00;
            zero_flag <= 1'b0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            ir        <= ir_nxt;
            zero_flag <= zero_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        ir_nxt    = ir;
        zero_nxt  = zero_flag;
        req_c     = 1'b0;
        rf_we     = 1'b0;
        rf_wdata  = alu_rd;
        case (state)
            S_FETCH: begin
                req_c = 1'b1;
                if (imem_ack) begin
                    ir_nxt    = imem_data;
                    pc_nxt    = pc + 8'd1;
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_alu_op(op))        state_nxt = S_EXEC;
                else if (has_operand(op)) state_nxt = S_FETCH_OP;
                else if (op == OP_HLT)    state_nxt = S_HALT;
                else                      state_nxt = S_FETCH;
            end
            S_EXEC: begin
                rf_we     = 1'b1;
                rf_wdata  = alu_rd;
                zero_nxt  = alu_is_zero;
                state_nxt = S_FETCH;
            end
            S_FETCH_OP: begin
                req_c = 1'b1;
                if (imem_ack) begin
                    if (op == OP_LDI) begin
                        rf_we    = 1'b1;
                        rf_wdata = imem_data;
                        pc_nxt   = pc + 8'd1;
                    end else begin
                        pc_nxt = zero_flag ? imem_data : pc + 8'd1;
                    end
                    state_nxt = S_FETCH;
                end
            end
            S_HALT: begin
                state_nxt = S_HALT;
            end
            default: state_nxt = S_FETCH;
        endcase
    end

    // Request is masked during reset so an ack in that cycle has nothing to complete.
    assign imem_req    = req_c & ~rst;
    assign imem_addr   = pc;
    assign alu_opcode  = (state == S_EXEC) ? op : 4'h0;
    assign alu_control = 2'b00;
    assign halted      = (state == S_HALT);
    assign fsm_state   = state;

    exec_regfile u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we       (rf_we),
        .waddr    (ir[3:2]),
        .wdata    (rf_wdata),
        .raddr_a  (ir[3:2]),
        .rdata_a  (alu_rs1),
        .raddr_b  (ir[1:0]),
        .rdata_b  (alu_rs2),
        .dbg_sel  (dbg_sel),
        .dbg_data (dbg_data)
    );

`ifdef EXEC_CTRL_RETIRE_CNT_EN
    logic retire;

    always_comb begin
        retire = 1'b0;
        case (state)
            S_DECODE:   retire = !is_alu_op(op) && !has_operand(op) && (op != OP_HLT);
            S_EXEC:     retire = 1'b1;
            S_FETCH_OP: retire = imem_ack;
            default:    retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)         retire_cnt <= 16'h0000;
        else if (retire) retire_cnt <= retire_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_exec_ctrl.sv
// Directed bench for exec_ctrl: memory and ALU models around the DUT, with
// hand-computed expectations checked on the falling clock edge.
module tb_exec_ctrl;
    import cpu_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack;
    logic [7:0] imem_data;
    logic [3:0] alu_opcode;
    logic [1:0] alu_control;
    logic [7:0] alu_rs1, alu_rs2, alu_rd;
    logic       alu_is_zero;
    logic [7:0] pc;
    logic       zero_flag;
    logic       halted;
    logic [1:0] dbg_sel;
    logic [7:0] dbg_data;
    state_t     fsm_state;
`ifdef EXEC_CTRL_RETIRE_CNT_EN
    logic [15:0] retire_cnt;
`endif

    logic [7:0] mem [256];
    logic       ack_en;
    logic       ack_force;
    int         n_checks = 0;
    int         n_fail   = 0;

    always #5 clk = ~clk;

    exec_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_data   (imem_data),
        .alu_opcode  (alu_opcode),
        .alu_control (alu_control),
        .alu_rs1     (alu_rs1),
        .alu_rs2     (alu_rs2),
        .alu_rd      (alu_rd),
        .alu_is_zero (alu_is_zero),
        .pc          (pc),
        .zero_flag   (zero_flag),
        .halted      (halted),
        .dbg_sel     (dbg_sel),
        .dbg_data    (dbg_data),
        .fsm_state   (fsm_state)
`ifdef EXEC_CTRL_RETIRE_CNT_EN
        ,
        .retire_cnt  (retire_cnt)
`endif
    );

    // Zero-wait memory unless ack_en is dropped; ack_force injects stray acks.
    assign imem_ack  = ack_force | (imem_req & ack_en);
    assign imem_data = mem[imem_addr];

    always_comb begin
        case (alu_opcode)
            4'h2:    alu_rd = alu_rs1 + alu_rs2;
            4'h3:    alu_rd = alu_rs1 & alu_rs2;
            4'h4:    alu_rd = alu_rs1 ^ alu_rs2;
            4'h5:    alu_rd = alu_rs2;
            default: alu_rd = 8'h00;
        endcase
        alu_is_zero = (alu_rd == 8'h00);
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_reg(input string tag, input logic [1:0] idx, input logic [7:0] exp);
        dbg_sel = idx;
        #1;
        check(tag, {8'h00, dbg_data}, {8'h00, exp});
    endtask

    task automatic check_state(input string tag, input state_t exp);
        check(tag, {13'h0, fsm_state}, {13'h0, exp});
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        // LDI r1,5; LDI r2,3; ADD r1,r2
        mem[8'h00] = 8'h84; mem[8'h01] = 8'h05;
        mem[8'h02] = 8'h88; mem[8'h03] = 8'h03;
        mem[8'h04] = 8'h26;
        // LDI r0,F0; LDI r3,0F; AND r0,r3; JZ 40
        mem[8'h05] = 8'h80; mem[8'h06] = 8'hF0;
        mem[8'h07] = 8'h8C; mem[8'h08] = 8'h0F;
        mem[8'h09] = 8'h33;
        mem[8'h0A] = 8'h90; mem[8'h0B] = 8'h40;
        // XOR r2,r1; ADD r1,r1; MOV r0,r1; XOR r3,r3; JZ FF
        mem[8'h40] = 8'h49;
        mem[8'h41] = 8'h25;
        mem[8'h42] = 8'h51;
        mem[8'h43] = 8'h4F;
        mem[8'h44] = 8'h90; mem[8'h45] = 8'hFF;
        mem[8'hFF] = 8'h00;

        rst = 1'b1; ack_en = 1'b1; ack_force = 1'b0; dbg_sel = 2'd0;
        tick(2);
        check("rst_req", {15'h0, imem_req}, 16'h0);
        check("rst_pc", {8'h0, pc}, 16'h0);
        check("rst_zero", {15'h0, zero_flag}, 16'h0);
        check("rst_halted", {15'h0, halted}, 16'h0);
        check_state("rst_state", S_FETCH);
        for (int i = 0; i < 4; i++) check_reg("rst_reg", 2'(i), 8'h00);

        rst = 1'b0;
        tick(9);
        check_reg("add_r1", 2'd1, 8'h08);
        check_reg("ldi_r2", 2'd2, 8'h03);
        check("add_zero", {15'h0, zero_flag}, 16'h0);
        check("add_pc", {8'h0, pc}, 16'h05);
`ifdef EXEC_CTRL_RETIRE_CNT_EN
        check("retire_3", retire_cnt, 16'd3);
`endif

        tick(9);
        check_reg("and_r0", 2'd0, 8'h00);
        check_reg("ldi_r3", 2'd3, 8'h0F);
        check("and_zero", {15'h0, zero_flag}, 16'h1);
        check("and_pc", {8'h0, pc}, 16'h0A);
        tick(3);
        check("jz_pc", {8'h0, pc}, 16'h40);

        ack_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check("stall_req", {15'h0, imem_req}, 16'h1);
            check("stall_addr", {8'h0, imem_addr}, 16'h40);
        end
        ack_en = 1'b1;
        tick(2);
        check_state("stall_exec", S_EXEC);
        check_reg("stall_r2_old", 2'd2, 8'h03);
        tick(1);
        check_reg("xor_r2", 2'd2, 8'h0B);
        check("xor_zero", {15'h0, zero_flag}, 16'h0);
        check("xor_pc", {8'h0, pc}, 16'h41);

        tick(3);
        check_reg("add_self_r1", 2'd1, 8'h10);
        tick(3);
        check_reg("mov_r0", 2'd0, 8'h10);
        tick(3);
        check_reg("xor_self_r3", 2'd3, 8'h00);
        check("xor_self_zero", {15'h0, zero_flag}, 16'h1);
        tick(3);
        check("jz_ff_pc", {8'h0, pc}, 16'hFF);
        tick(2);
        check("wrap_pc", {8'h0, pc}, 16'h00);
        check("wrap_addr", {8'h0, imem_addr}, 16'h00);
        check_state("wrap_state", S_FETCH);
`ifdef EXEC_CTRL_RETIRE_CNT_EN
        check("retire_13", retire_cnt, 16'd13);
`endif

        rst = 1'b1;
        mem[8'h00] = 8'hF0;
        tick(1);
        rst = 1'b0;
        tick(2);
        check("hlt_halted", {15'h0, halted}, 16'h1);
        check("hlt_pc", {8'h0, pc}, 16'h01);
        for (int i = 0; i < 10; i++) begin
            ack_force = i[0];
            tick(1);
            check("hlt_req", {15'h0, imem_req}, 16'h0);
        end
        ack_force = 1'b0;
        check("hlt_pc_hold", {8'h0, pc}, 16'h01);
        check_state("hlt_state", S_HALT);
        check_reg("hlt_r1", 2'd1, 8'h00);
`ifdef EXEC_CTRL_RETIRE_CNT_EN
        check("retire_hlt", retire_cnt, 16'd0);
`endif
        rst = 1'b1;
        tick(1);
        check("unhalt_pc", {8'h0, pc}, 16'h00);
        check("unhalt_halted", {15'h0, halted}, 16'h0);
        check("unhalt_req", {15'h0, imem_req}, 16'h0);

        mem[8'h00] = 8'h84; mem[8'h01] = 8'hAA;
        rst = 1'b0;
        tick(2);
        check_state("ldi_fetch_op", S_FETCH_OP);
        rst = 1'b1; ack_force = 1'b1;
        tick(1);
        check_reg("rst_ldi_r1", 2'd1, 8'h00);
        check("rst_ldi_pc", {8'h0, pc}, 16'h00);
        check_state("rst_ldi_state", S_FETCH);
`ifdef EXEC_CTRL_RETIRE_CNT_EN
        check("rst_ldi_retire", retire_cnt, 16'd0);
`endif
        rst = 1'b0; ack_force = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/exec_ctrl.md
EXEC_CTRL -- requirements
Module: exec_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-002 The block SHALL provide these instruction-memory ports: imem_req  out 1  fetch request; imem_addr  out 8  fetch address; imem_ack  in 1  data valid this cycle; imem_data  in 8  fetched byte.
REQ-003 The block SHALL provide these ALU-facing ports: alu_opcode  out 4  ALU operation; alu_control  out 2  tied 2'b00; alu_rs1  out 8  operand A; alu_rs2  out 8  operand B; alu_rd  in 8  ALU result; alu_is_zero  in 1  ALU zero indication.
REQ-004 The block SHALL provide these status and debug ports: pc  out 8  program counter; zero_flag  out 1  registered Z; halted  out 1  HALT state; dbg_sel  in 2  register index; dbg_data  out 8  regfile[dbg_sel], combinational.

Function
REQ-005 Instruction byte format SHALL be [7:4] opcode, [3:2] rd/rs1 index, [1:0] rs2 index; the register file SHALL be 4 x 8-bit.
REQ-006 ALU opcodes SHALL be 0x2 ADD, 0x3 AND, 0x4 XOR, 0x5 MOV; control opcodes SHALL be 0x8 LDI, 0x9 JZ, 0xF HLT; all other opcodes SHALL execute as NOP.
REQ-007 The FSM states SHALL be FETCH, DECODE, EXEC, FETCH_OP and HALT.
REQ-008 In FETCH: imem_req=1 and imem_addr=pc, both held stable until imem_ack; on ack, IR<=imem_data, pc<=pc+1 and the next state is DECODE.
REQ-009 In DECODE: ALU opcode -> EXEC; LDI/JZ -> FETCH_OP; HLT -> HALT; NOP -> FETCH.
REQ-010 In EXEC: alu_opcode=IR[7:4], alu_rs1=reg[IR[3:2]], alu_rs2=reg[IR[1:0]]; at the clock edge, reg[IR[3:2]]<=alu_rd and zero_flag<=alu_is_zero; the next state is FETCH.
REQ-011 Outside EXEC: alu_opcode=4'h0, and alu_rs1/alu_rs2 SHALL hold their decoded values.
REQ-012 In FETCH_OP the handshake SHALL be as in FETCH (addr=pc); on ack: LDI -> reg[IR[3:2]]<=imem_data, pc<=pc+1, zero_flag unchanged; JZ -> pc<=imem_data if zero_flag=1, else pc<=pc+1; the next state is FETCH.
REQ-013 Latency with zero-wait memory SHALL be: ALU instruction 3 cycles; NOP 2 cycles; LDI/JZ 3 cycles.
REQ-014 pc SHALL wrap 8'hFF -> 8'h00 on increment, with no flag raised.
REQ-015 HALT SHALL be absorbing until rst: halted=1, imem_req=0, no register or pc change.
REQ-016 imem_ack while imem_req=0 SHALL be ignored.
REQ-017 A destination register equal to a source register SHALL read the old value and write the result.

Reset
REQ-018 On rst the block SHALL set state=FETCH, pc=8'h00, IR=8'h00, regs=8'h00, zero_flag=0, halted=0, imem_req=0 in the cycle after reset.
REQ-019 On reset asserted mid-fetch, any imem_ack in that cycle SHALL be discarded, and no register, pc or flag SHALL update.
REQ-020 rst SHALL have priority over every other event.

Configuration
REQ-021 With EXEC_CTRL_RETIRE_CNT_EN defined, the block SHALL add output retire_cnt (16 bits, reset 0), incremented once per completed ALU, LDI, JZ or NOP instruction, wrapping at 16'hFFFF -> 0, and not incremented for HLT.
REQ-022 Without EXEC_CTRL_RETIRE_CNT_EN, the port and the counter SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-023 Package cpu_pkg SHALL hold the opcode enum (4-bit), the FSM state enum, and the constants REG_W=8 and NREGS=4.
REQ-024 The register file SHALL be the sub-module exec_regfile: 2 combinational read ports, 1 synchronous write port, and a debug read port.

Verification
REQ-025 The bench SHALL cover: reset, then LDI r1,0x05; LDI r2,0x03; ADD r1,r2 (0x26) -> r1=0x08, zero_flag=0, pc=0x05.
REQ-026 The bench SHALL cover: LDI r0,0xF0; LDI r3,0x0F; AND r0,r3 (0x33) -> r0=0x00, zero_flag=1 (ALU reports zero); JZ 0x40 -> pc=0x40.
REQ-027 The bench SHALL cover: imem_ack withheld 4 cycles in FETCH -> imem_req=1 and imem_addr constant throughout; instruction completes 4 cycles late.
REQ-028 The bench SHALL cover: pc=0xFF fetching 0x00 (NOP) -> pc=0x00 afterwards; instruction fetched from 0x00 next.
REQ-029 The bench SHALL cover: HLT (0xF0) -> halted=1 within 2 cycles; toggling imem_ack for 10 cycles -> no state change; rst -> pc=0, halted=0.
REQ-030 The bench SHALL cover: rst asserted during FETCH_OP of LDI r1,0xAA with ack in the same cycle -> r1 stays 0x00; retire_cnt=0 when EXEC_CTRL_RETIRE_CNT_EN is defined.
